issue_ctrl: RTL and testbench
=============================

ISSUE_CTRL -- requirements
Module: issue_ctrl

Interface
REQ-001 SHALL have ports: clk  in  1  sole clock, rising edge.
REQ-002 SHALL have: rst  in  1  reset, asynchronous, active-low.
REQ-003 SHALL have: rdy  in  1  global enable; low freezes all state.
REQ-004 SHALL have: iINF_en  in  1 / iINF_inst  in  32 / iINF_pc  in  32 / iINF_pd  in  1; fetched instruction, PC, predicted-jump bit.
REQ-005 SHALL have: oINF_full  out  1  backpressure to fetcher.
REQ-006 SHALL have: iROB_full  in  1 / iRS_full  in  1 / iLSB_full  in  1; downstream occupancy.
REQ-007 SHALL have: iROB_clr  in  1  mispredict flush.
REQ-008 SHALL have: oDEC_en  out  1 / oDEC_inst  out  32 / oDEC_pc  out  32 / oDEC_pd  out  1; registered issue to decoder.

Function
REQ-009 SHALL buffer instructions in a circular FIFO of `IQ_DEPTH` (16) entries {inst, pc, pd}, head/tail pointers wrap modulo depth.
REQ-010 SHALL enqueue at an edge when rdy && iINF_en && !iROB_clr && (count < `IQ_DEPTH` || issue same edge).
REQ-011 SHALL drop iINF_en when count == `IQ_DEPTH` with no issue that edge (fetcher protocol violation).
REQ-012 SHALL drive oINF_full = (count >= `IQ_DEPTH`-1), combinational from count, giving one-slot margin.
REQ-013 SHALL classify head as memory op when inst[6:0] is `OPC_LOAD` (0000011) or `OPC_STORE` (0100011).
REQ-014 SHALL issue at an edge when rdy && !empty && !iROB_clr && !iROB_full && (mem ? !iLSB_full : !iRS_full).
REQ-015 SHALL, on issue, load head into oDEC_inst/pc/pd, set oDEC_en=1 for exactly one cycle, advance head.
REQ-016 SHALL set oDEC_en=0 at any edge without issue; oDEC_inst/pc/pd hold last value.
REQ-017 SHALL issue at most one instruction per cycle, strictly in program order.
REQ-018 SHALL keep count unchanged on simultaneous enqueue and issue, including at full and at count==1.
REQ-019 SHALL, when iROB_clr sampled high, reset head, tail, count to 0, set oDEC_en=0, drop same-edge iINF_en; flush beats enqueue and issue.
REQ-020 SHALL hold all state, including oDEC_en, at edges where rdy is low; iROB_clr ignored then.
REQ-021 SHALL, without bypass, have minimum latency 1 edge from enqueue edge to issue edge (oDEC_en visible 2 cycles after iINF_en cycle).

Reset
REQ-022 SHALL on rst low immediately clear head, tail, count, oDEC_en, oDEC_inst, oDEC_pc, oDEC_pd to 0, independent of clk and rdy.
REQ-023 SHALL make oINF_full 0 during and after reset; reset mid-operation discards all queued entries.

Configuration
REQ-024 SHALL honour macro ISSUE_BYPASS_EN: when defined, an instruction arriving with queue empty and REQ-014 downstream conditions met is written directly to oDEC_* at the same edge, not enqueued (latency 0 edges).
REQ-025 SHALL, without ISSUE_BYPASS_EN, always route through the FIFO per REQ-021; flush and rdy rules identical in both builds.

Structure
REQ-026 SHALL take `IQ_DEPTH`, `IQ_PTR_W` (4), `OPC_LOAD`, `OPC_STORE`, `InstBus`, `AddrBus` from shared config.v.
REQ-027 SHALL place storage in one sub-module inst_fifo (write port, read-head port, pointer wrap); control, full logic, issue and flush stay in issue_ctrl.

Verification
REQ-028 Enqueue ADDI (0x00100093, pc 0x0) with all full flags low -> oDEC_en pulse 2 cycles later, oDEC_pc=0x0; with ISSUE_BYPASS_EN, next cycle.
REQ-029 Fill 16 instructions with iROB_full=1 -> count 16, oINF_full high from count 15; 17th iINF_en dropped; release -> 16 issues in order, pc 0x0..0x3C.
REQ-030 Head LW (opcode 0000011) with iLSB_full=1, iRS_full=0 -> no issue; head ADD with iRS_full=1, iLSB_full=0 -> no issue.
REQ-031 Queue 5 entries, assert iROB_clr with iINF_en high -> next cycle count 0, oDEC_en 0, new instruction not stored.
REQ-032 Hold rdy low 3 cycles mid-stream -> no pointer/output change; rst low mid-stream -> all outputs 0 immediately, queue empty after release.

Source files
------------

// File: rtl/issue_ctrl_pkg.sv
// Shared configuration for the issue queue: depth, pointer width, opcode
// constants, bus widths and the queue entry layout.
package issue_ctrl_pkg;

  localparam int IQ_DEPTH = 16;
  localparam int IQ_PTR_W = 4;
  localparam int InstBus  = 32;
  localparam int AddrBus  = 32;

  localparam logic [6:0] OPC_LOAD  = 7'b0000011;
  localparam logic [6:0] OPC_STORE = 7'b0100011;

  // Occupancy thresholds, sized to the count register (one bit wider than a pointer).
  localparam logic [IQ_PTR_W:0] CNT_FULL  = (IQ_PTR_W+1)'(IQ_DEPTH);
  localparam logic [IQ_PTR_W:0] CNT_AFULL = (IQ_PTR_W+1)'(IQ_DEPTH - 1);

  typedef struct packed {
    logic [InstBus-1:0] inst;
    logic [AddrBus-1:0] pc;
    logic               pd;
  } iq_entry_t;

  function automatic logic is_mem_op(input logic [InstBus-1:0] inst);
    return (inst[6:0] == OPC_LOAD) || (inst[6:0] == OPC_STORE);
  endfunction

endpackage

// File: rtl/issue_ctrl_inst_fifo.sv
// Circular instruction storage with a write port at the tail and a read port
// at the head; pointers wrap naturally at IQ_DEPTH. Occupancy lives in issue_ctrl.
module inst_fifo
  import issue_ctrl_pkg::*;
(
  input  logic      clk,
  input  logic      rst,
  input  logic      clr_i,
  input  logic      wr_en_i,
  input  iq_entry_t wr_data_i,
  input  logic      rd_adv_i,
  output iq_entry_t head_o
);

  logic [IQ_PTR_W-1:0] head_q, head_d;
  logic [IQ_PTR_W-1:0] tail_q, tail_d;
  iq_entry_t           mem_q [IQ_DEPTH];

  always_comb begin
    head_d = head_q;
    tail_d = tail_q;
    if (clr_i) begin
      head_d = '0;
      tail_d = '0;
    end else begin
      if (rd_adv_i) head_d = head_q + 1'b1;
      if (wr_en_i)  tail_d = tail_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      head_q <= '0;
      tail_q <= '0;
    end else begin
      head_q <= head_d;
      tail_q <= tail_d;
    end
  end

  // Storage needs no reset: an entry is only read after it has been written.
  always_ff @(posedge clk) begin
    if (wr_en_i) mem_q[tail_q] <= wr_data_i;
  end

  assign head_o = mem_q[head_q];

endmodule

// File: rtl/issue_ctrl.sv
// In-order issue controller: buffers fetched instructions and issues one per
// cycle to the decoder when downstream has room. ISSUE_BYPASS_EN enables a
// zero-latency path from fetch straight to the decoder when the queue is empty.
//
// Handshake: an instruction is taken at an edge where rdy && iINF_en && !iROB_clr
// and the queue has room (or issues that edge); oDEC_en is a single-cycle strobe
// qualifying oDEC_inst/pc/pd. oINF_full is the fetcher's backpressure.
module issue_ctrl
  import issue_ctrl_pkg::*;
(
  input  logic               clk,
  input  logic               rst,
  input  logic               rdy,
  input  logic               iINF_en,
  input  logic [InstBus-1:0] iINF_inst,
  input  logic [AddrBus-1:0] iINF_pc,
  input  logic               iINF_pd,
  output logic               oINF_full,
  input  logic               iROB_full,
  input  logic               iRS_full,
  input  logic               iLSB_full,
  input  logic               iROB_clr,
  output logic               oDEC_en,
  output logic [InstBus-1:0] oDEC_inst,
  output logic [AddrBus-1:0] oDEC_pc,
  output logic               oDEC_pd,
  output logic [IQ_PTR_W:0]  oDBG_count
);

  logic [IQ_PTR_W:0] count_q, count_d;
  logic              dec_en_q, dec_en_d;
  iq_entry_t         dec_q, dec_d;
  iq_entry_t         head;
  iq_entry_t         in_entry;
  logic              empty, full;
  logic              issue, bypass, enq_fifo, flush;

  assign in_entry = '{inst: iINF_inst, pc: iINF_pc, pd: iINF_pd};
  assign empty    = (count_q == '0);
  assign full     = (count_q == CNT_FULL);
  assign flush    = rdy && iROB_clr;

  assign issue = rdy && !empty && !iROB_clr && !iROB_full &&
                 (is_mem_op(head.inst) ? !iLSB_full : !iRS_full);

`ifdef ISSUE_BYPASS_EN
  logic in_mem;
  assign in_mem = is_mem_op(iINF_inst);
  assign bypass = rdy && iINF_en && !iROB_clr && empty && !iROB_full &&
                  (in_mem ? !iLSB_full : !iRS_full);
`else
  assign bypass = 1'b0;
`endif

  // A bypassed instruction never occupies a slot.
  assign enq_fifo = rdy && iINF_en && !iROB_clr && (!full || issue) && !bypass;

  inst_fifo u_fifo (
    .clk       (clk),
    .rst       (rst),
    .clr_i     (flush),
    .wr_en_i   (enq_fifo),
    .wr_data_i (in_entry),
    .rd_adv_i  (issue),
    .head_o    (head)
  );

  always_comb begin
    count_d  = count_q;
    dec_en_d = dec_en_q;
    dec_d    = dec_q;
    if (rdy) begin
      if (iROB_clr) begin
        count_d  = '0;
        dec_en_d = 1'b0;
      end else begin
        case ({enq_fifo, issue})
          2'b10:   count_d = count_q + 1'b1;
          2'b01:   count_d = count_q - 1'b1;
          default: count_d = count_q;
        endcase
        if (issue) begin
          dec_d    = head;
          dec_en_d = 1'b1;
        end else if (bypass) begin
          dec_d    = in_entry;
          dec_en_d = 1'b1;
        end else begin
          dec_en_d = 1'b0;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      count_q  <= '0;
      dec_en_q <= 1'b0;
      dec_q    <= '0;
    end else begin
      count_q  <= count_d;
      dec_en_q <= dec_en_d;
      dec_q    <= dec_d;
    end
  end

  assign oINF_full  = (count_q >= CNT_AFULL);
  assign oDEC_en    = dec_en_q;
  assign oDEC_inst  = dec_q.inst;
  assign oDEC_pc    = dec_q.pc;
  assign oDEC_pd    = dec_q.pd;
  assign oDBG_count = count_q;

endmodule

// File: tb/tb_issue_ctrl.sv
// Bench for issue_ctrl: queue-based reference model checked every cycle,
// plus directed scenarios with literal expectations.
module tb_issue_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        rdy = 1'b0;
  logic        iINF_en = 1'b0;
  logic [31:0] iINF_inst = '0;
  logic [31:0] iINF_pc = '0;
  logic        iINF_pd = 1'b0;
  logic        oINF_full;
  logic        iROB_full = 1'b0;
  logic        iRS_full = 1'b0;
  logic        iLSB_full = 1'b0;
  logic        iROB_clr = 1'b0;
  logic        oDEC_en;
  logic [31:0] oDEC_inst;
  logic [31:0] oDEC_pc;
  logic        oDEC_pd;
  logic [4:0]  oDBG_count;

  localparam logic [31:0] I_ADDI = 32'h00100093;
  localparam logic [31:0] I_LW   = 32'h00002083;
  localparam logic [31:0] I_SW   = 32'h00112023;
  localparam logic [31:0] I_ADD  = 32'h002081b3;

  int n_pass  = 0;
  int n_total = 0;

  issue_ctrl dut (
    .clk        (clk),
    .rst        (rst),
    .rdy        (rdy),
    .iINF_en    (iINF_en),
    .iINF_inst  (iINF_inst),
    .iINF_pc    (iINF_pc),
    .iINF_pd    (iINF_pd),
    .oINF_full  (oINF_full),
    .iROB_full  (iROB_full),
    .iRS_full   (iRS_full),
    .iLSB_full  (iLSB_full),
    .iROB_clr   (iROB_clr),
    .oDEC_en    (oDEC_en),
    .oDEC_inst  (oDEC_inst),
    .oDEC_pc    (oDEC_pc),
    .oDEC_pd    (oDEC_pd),
    .oDBG_count (oDBG_count)
  );

  // ---------------- clock ----------------
  always #5 clk = ~clk;

  // ---------------- reference model ----------------
  // exp_q holds queued entries as {pd, pc, inst}, front = oldest.
  logic [64:0] exp_q[$];
  logic        m_en   = 1'b0;
  logic [31:0] m_inst = '0;
  logic [31:0] m_pc   = '0;
  logic        m_pd   = 1'b0;

  function automatic logic mem_op(input logic [31:0] inst);
    return (inst[6:0] == 7'b0000011) || (inst[6:0] == 7'b0100011);
  endfunction

  function automatic logic room_for(input logic [31:0] inst);
    return !iROB_full && (mem_op(inst) ? !iLSB_full : !iRS_full);
  endfunction

  always @(posedge clk or negedge rst) begin
    logic [64:0] e;
    logic        can_issue, byp;
    int          sz;
    if (!rst) begin
      exp_q.delete();
      m_en = 1'b0; m_inst = '0; m_pc = '0; m_pd = 1'b0;
    end else if (rdy) begin
      if (iROB_clr) begin
        exp_q.delete();
        m_en = 1'b0;
      end else begin
        sz        = exp_q.size();
        can_issue = (sz > 0) && room_for(exp_q[0][31:0]);
        byp       = 1'b0;
`ifdef ISSUE_BYPASS_EN
        byp = iINF_en && (sz == 0) && room_for(iINF_inst);
`endif
        if (can_issue) begin
          e = exp_q.pop_front();
          m_en = 1'b1; m_inst = e[31:0]; m_pc = e[63:32]; m_pd = e[64];
        end else if (byp) begin
          m_en = 1'b1; m_inst = iINF_inst; m_pc = iINF_pc; m_pd = iINF_pd;
        end else begin
          m_en = 1'b0;
        end
        if (iINF_en && !byp && (sz < 16 || can_issue))
          exp_q.push_back({iINF_pd, iINF_pc, iINF_inst});
      end
    end
  end

  // ---------------- scoreboard ----------------
  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
  endtask

  always @(negedge clk) begin
    chk("m_dec_en",   64'(oDEC_en),    64'(m_en));
    chk("m_dec_inst", 64'(oDEC_inst),  64'(m_inst));
    chk("m_dec_pc",   64'(oDEC_pc),    64'(m_pc));
    chk("m_dec_pd",   64'(oDEC_pd),    64'(m_pd));
    chk("m_count",    64'(oDBG_count), 64'(exp_q.size()));
    chk("m_inf_full", 64'(oINF_full),  64'(exp_q.size() >= 15));
  end

  // ---------------- driver tasks ----------------
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic en, input logic [31:0] inst, input logic [31:0] pc,
                       input logic pd);
    iINF_en = en; iINF_inst = inst; iINF_pc = pc; iINF_pd = pd;
  endtask

  // ---------------- directed stimulus ----------------
  initial begin
    // reset state
    cyc(); cyc();
    chk("rst_dec_en", 64'(oDEC_en), 64'd0);
    chk("rst_full",   64'(oINF_full), 64'd0);
    chk("rst_count",  64'(oDBG_count), 64'd0);
    rst = 1'b1; rdy = 1'b1;
    cyc();

    // single ADDI, latency check
    drive(1'b1, I_ADDI, 32'h0, 1'b0);
    cyc();
    drive(1'b0, '0, '0, 1'b0);
`ifdef ISSUE_BYPASS_EN
    chk("lat_en_e1", 64'(oDEC_en), 64'd1);
    chk("lat_pc_e1", 64'(oDEC_pc), 64'h0);
    cyc();
    chk("lat_en_e2", 64'(oDEC_en), 64'd0);
`else
    chk("lat_en_e1", 64'(oDEC_en), 64'd0);
    cyc();
    chk("lat_en_e2", 64'(oDEC_en), 64'd1);
    chk("lat_pc_e2", 64'(oDEC_pc), 64'h0);
    chk("lat_inst",  64'(oDEC_inst), 64'(I_ADDI));
    cyc();
    chk("lat_en_e3", 64'(oDEC_en), 64'd0);
`endif
    cyc();

    // fill 16 with ROB full, 17th dropped, then drain in order
    iROB_full = 1'b1;
    for (int i = 0; i < 16; i++) begin
      drive(1'b1, I_ADDI, 32'(i * 4), i[0]);
      cyc();
      chk("fill_count", 64'(oDBG_count), 64'(i + 1));
      chk("fill_full",  64'(oINF_full),  64'(i + 1 >= 15));
    end
    drive(1'b1, I_ADDI, 32'h40, 1'b0);
    cyc();
    chk("drop_count", 64'(oDBG_count), 64'd16);
    drive(1'b0, '0, '0, 1'b0);
    iROB_full = 1'b0;
    for (int i = 0; i < 16; i++) begin
      cyc();
      chk("drain_en", 64'(oDEC_en), 64'd1);
      chk("drain_pc", 64'(oDEC_pc), 64'(i * 4));
      chk("drain_pd", 64'(oDEC_pd), 64'(i % 2));
    end
    cyc();
    chk("drain_done_en", 64'(oDEC_en), 64'd0);
    chk("drain_done_cnt", 64'(oDBG_count), 64'd0);

    // full with simultaneous issue and enqueue keeps count
    iROB_full = 1'b1;
    for (int i = 0; i < 16; i++) begin
      drive(1'b1, I_ADD, 32'h200 + 32'(i * 4), 1'b0);
      cyc();
    end
    iROB_full = 1'b0;
    drive(1'b1, I_ADD, 32'h300, 1'b1);
    cyc();
    chk("full_swap_cnt", 64'(oDBG_count), 64'd16);
    chk("full_swap_pc",  64'(oDEC_pc), 64'h200);
    drive(1'b0, '0, '0, 1'b0);
    for (int i = 0; i < 17; i++) cyc();
    chk("full_swap_last", 64'(oDEC_pc), 64'h300);

    // memory-op routing
    iLSB_full = 1'b1;
    drive(1'b1, I_LW, 32'h500, 1'b0);
    cyc();
    drive(1'b0, '0, '0, 1'b0);
    cyc(); cyc();
    chk("lw_blk_en",  64'(oDEC_en), 64'd0);
    chk("lw_blk_cnt", 64'(oDBG_count), 64'd1);
    iLSB_full = 1'b0;
    cyc();
    chk("lw_go_pc", 64'(oDEC_pc), 64'h500);
    iRS_full = 1'b1;
    drive(1'b1, I_ADD, 32'h504, 1'b0);
    cyc();
    drive(1'b0, '0, '0, 1'b0);
    cyc(); cyc();
    chk("add_blk_en",  64'(oDEC_en), 64'd0);
    chk("add_blk_cnt", 64'(oDBG_count), 64'd1);
    iRS_full = 1'b0;
    cyc(); cyc();

    // flush with same-edge enqueue
    iROB_full = 1'b1;
    for (int i = 0; i < 5; i++) begin
      drive(1'b1, I_SW, 32'h600 + 32'(i * 4), 1'b0);
      cyc();
    end
    iROB_clr = 1'b1;
    drive(1'b1, I_ADDI, 32'h700, 1'b0);
    cyc();
    iROB_clr = 1'b0;
    drive(1'b0, '0, '0, 1'b0);
    chk("clr_cnt", 64'(oDBG_count), 64'd0);
    chk("clr_en",  64'(oDEC_en), 64'd0);
    iROB_full = 1'b0;
    cyc();
    chk("clr_nostore", 64'(oDEC_en), 64'd0);

    // rdy low freezes everything, including flush
    iROB_full = 1'b1;
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, I_ADDI, 32'h800 + 32'(i * 4), 1'b0);
      cyc();
    end
    rdy = 1'b0; iROB_clr = 1'b1; iROB_full = 1'b0;
    for (int i = 0; i < 3; i++) begin
      cyc();
      chk("frz_cnt", 64'(oDBG_count), 64'd3);
      chk("frz_en",  64'(oDEC_en), 64'd0);
    end
    rdy = 1'b1; iROB_clr = 1'b0;
    drive(1'b0, '0, '0, 1'b0);
    cyc();
    chk("unfrz_pc", 64'(oDEC_pc), 64'h800);

    // async reset mid-stream
    #2;
    rst = 1'b0;
    #1;
    chk("arst_en",   64'(oDEC_en), 64'd0);
    chk("arst_pc",   64'(oDEC_pc), 64'd0);
    chk("arst_inst", 64'(oDEC_inst), 64'd0);
    chk("arst_cnt",  64'(oDBG_count), 64'd0);
    cyc();
    rst = 1'b1;
    cyc();
    chk("arst_empty", 64'(oDBG_count), 64'd0);

    // mixed traffic, checked by the model every cycle
    for (int i = 0; i < 60; i++) begin
      case (i % 4)
        0:       drive(i % 4 != 3, I_ADDI, 32'h1000 + 32'(i * 4), i[1]);
        1:       drive(1'b1, I_LW,  32'h1000 + 32'(i * 4), i[1]);
        2:       drive(1'b1, I_SW,  32'h1000 + 32'(i * 4), i[1]);
        default: drive(1'b0, I_ADD, 32'h1000 + 32'(i * 4), i[1]);
      endcase
      iROB_full = (i % 7 == 5);
      iRS_full  = (i % 5 == 2);
      iLSB_full = (i % 6 == 1);
      iROB_clr  = (i == 30);
      rdy       = (i % 11 != 4);
      cyc();
    end
    drive(1'b0, '0, '0, 1'b0);
    iROB_full = 1'b0; iRS_full = 1'b0; iLSB_full = 1'b0; iROB_clr = 1'b0; rdy = 1'b1;
    for (int i = 0; i < 20; i++) cyc();
    chk("mix_empty", 64'(oDBG_count), 64'd0);

    @(negedge clk);
    #1;
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
